// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: launch, stall, redirect bubble, halt.
// Optional counters enabled by defining PC_SEQUENCER_STATS_EN.
module pc_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              fetch_ready,
    input  logic              exec_valid,
    input  logic              exec_is_branch,
    input  logic              exec_is_jump,
    input  logic              exec_is_halt,
    input  logic [ADDR_W-1:0] exec_target,
    input  logic [31:0]       alu_result,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic              flush,
    output logic              busy,
    output logic              done,
    output logic [31:0]       redirect_count,
    output logic [31:0]       stall_count
);

    typedef enum logic [1:0] {IDLE, RUN, REDIRECT, HALTED} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic              flush_nx;
    logic              in_run, start_acc;
    logic              do_halt, do_jump, do_br;

    assign in_run    = (state == RUN);
    assign start_acc = start && (state == IDLE || state == HALTED);

    // Mutually exclusive resolution with halt > jump > taken branch
    assign do_halt = in_run && exec_valid && exec_is_halt;
    assign do_jump = in_run && exec_valid && !exec_is_halt && exec_is_jump;
    assign do_br   = in_run && exec_valid && !exec_is_halt && !exec_is_jump
                     && exec_is_branch && (alu_result != 32'd0);

    always_comb begin
        state_nx = state;
        pc_nx    = fetch_pc;
        flush_nx = 1'b0;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_nx    = start_pc;
                    state_nx = RUN;
                end
            end
            RUN: begin
                unique case (1'b1)
                    do_halt: begin
                        flush_nx = 1'b1;
                        state_nx = HALTED;
                    end
                    do_jump: begin
                        pc_nx    = alu_result[ADDR_W-1:0];
                        flush_nx = 1'b1;
                        state_nx = REDIRECT;
                    end
                    do_br: begin
                        pc_nx    = exec_target;
                        flush_nx = 1'b1;
                        state_nx = REDIRECT;
                    end
                    default: begin
                        if (fetch_ready)
                            pc_nx = fetch_pc + ADDR_W'(PC_STEP);
                    end
                endcase
            end
            REDIRECT: state_nx = RUN;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= '0;
            flush    <= 1'b0;
        end else begin
            state    <= state_nx;
            fetch_pc <= pc_nx;
            flush    <= flush_nx;
        end
    end

    assign fetch_valid = in_run;
    assign busy        = in_run || (state == REDIRECT);
    assign done        = (state == HALTED);

`ifdef PC_SEQUENCER_STATS_EN
    logic [31:0] rc_q, sc_q;
    logic        do_stall;

    assign do_stall = in_run && !fetch_ready && !(do_halt || do_jump || do_br);

    always_ff @(posedge clk) begin
        if (!reset_n || start_acc) begin
            rc_q <= '0;
            sc_q <= '0;
        end else begin
            if ((do_jump || do_br) && rc_q != 32'hFFFF_FFFF)
                rc_q <= rc_q + 32'd1;
            if (do_stall && sc_q != 32'hFFFF_FFFF)
                sc_q <= sc_q + 32'd1;
        end
    end

    assign redirect_count = rc_q;
    assign stall_count    = sc_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign redirect_count   = 32'd0;
    assign stall_count      = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan plus randomized run against a model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, fetch_ready, exec_valid;
    logic        exec_is_branch, exec_is_jump, exec_is_halt;
    logic [31:0] start_pc, exec_target, alu_result;
    logic [31:0] fetch_pc, redirect_count, stall_count;
    logic        fetch_valid, flush, busy, done;

    int n_chk = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
        .fetch_ready(fetch_ready), .exec_valid(exec_valid),
        .exec_is_branch(exec_is_branch), .exec_is_jump(exec_is_jump),
        .exec_is_halt(exec_is_halt), .exec_target(exec_target),
        .alu_result(alu_result), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .flush(flush), .busy(busy), .done(done),
        .redirect_count(redirect_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

`ifdef PC_SEQUENCER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Model: mode 0 idle, 1 running, 2 bubble, 3 halted
    int          mmode;
    logic [31:0] mpc;
    bit          mflush;
    longint      mrc, msc;
    bit          mknown = 1'b0;

    always @(posedge clk) begin
        bit redir;
        redir = 1'b0;
        if (!reset_n) begin
            mmode = 0; mpc = 0; mflush = 0; mrc = 0; msc = 0;
            mknown = 1'b1;
        end else begin
            mflush = 0;
            if (mmode == 0 || mmode == 3) begin
                if (start) begin
                    mpc = start_pc; mmode = 1; mrc = 0; msc = 0;
                end
            end else if (mmode == 2) begin
                mmode = 1;
            end else if (exec_valid && exec_is_halt) begin
                mmode = 3; mflush = 1;
            end else if (exec_valid && exec_is_jump) begin
                mpc = alu_result; redir = 1;
            end else if (exec_valid && exec_is_branch && alu_result != 0) begin
                mpc = exec_target; redir = 1;
            end else if (fetch_ready) begin
                mpc = mpc + 1;
            end else begin
                msc = (msc < 64'hFFFF_FFFF) ? msc + 1 : msc;
            end
            if (redir) begin
                mmode = 2; mflush = 1;
                mrc = (mrc < 64'hFFFF_FFFF) ? mrc + 1 : mrc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mknown) begin
            chk("m_pc", fetch_pc, mpc);
            chk("m_valid", 32'(fetch_valid), 32'(mmode == 1));
            chk("m_busy", 32'(busy), 32'(mmode == 1 || mmode == 2));
            chk("m_done", 32'(done), 32'(mmode == 3));
            chk("m_flush", 32'(flush), 32'(mflush));
            chk("m_rcnt", redirect_count, STATS ? mrc[31:0] : 32'd0);
            chk("m_scnt", stall_count, STATS ? msc[31:0] : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_exec();
        exec_valid = 0; exec_is_branch = 0; exec_is_jump = 0;
        exec_is_halt = 0;
    endtask

    initial begin
        reset_n = 0; start = 0; start_pc = 0; fetch_ready = 0;
        exec_target = 0; alu_result = 0;
        idle_exec();
        @(negedge clk);
        step(); step();
        reset_n = 1;
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        start = 1; start_pc = 32'h10; fetch_ready = 1;
        step();
        start = 0;
        chk("launch_pc", fetch_pc, 32'h10);
        chk("launch_model_pc", mpc, 32'h10);
        chk("launch_valid", 32'(fetch_valid), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        step(); chk("seq_pc1", fetch_pc, 32'h11);
        step(); chk("seq_pc2", fetch_pc, 32'h12);

        for (int i = 0; i < 14; i++) step();
        chk("pre_stall_pc", fetch_pc, 32'h20);
        fetch_ready = 0;
        step(); step(); step();
        chk("stall_pc", fetch_pc, 32'h20);
        chk("stall_cnt", stall_count, STATS ? 32'd3 : 32'd0);

        fetch_ready = 1; exec_valid = 1; exec_is_jump = 1;
        alu_result = 32'h40;
        step();
        idle_exec();
        chk("jal_flush", 32'(flush), 32'd1);
        chk("jal_bubble", 32'(fetch_valid), 32'd0);
        step();
        chk("jal_flush_end", 32'(flush), 32'd0);
        chk("jal_pc", fetch_pc, 32'h40);
        chk("jal_valid", 32'(fetch_valid), 32'd1);
        chk("jal_rcnt", redirect_count, STATS ? 32'd1 : 32'd0);

        exec_valid = 1; exec_is_branch = 1; alu_result = 0;
        exec_target = 32'h80;
        step();
        chk("beqz_nt_pc", fetch_pc, 32'h41);
        chk("beqz_nt_flush", 32'(flush), 32'd0);
        alu_result = 1;
        step();
        idle_exec();
        chk("beqz_t_flush", 32'(flush), 32'd1);
        step();
        chk("beqz_t_pc", fetch_pc, 32'h80);
        chk("beqz_t_model", mpc, 32'h80);

        exec_valid = 1; exec_is_halt = 1; exec_is_jump = 1;
        alu_result = 32'h99;
        step();
        idle_exec();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_valid", 32'(fetch_valid), 32'd0);
        chk("halt_flush", 32'(flush), 32'd1);
        chk("halt_pc", fetch_pc, 32'h80);
        step();
        chk("halt_flush_end", 32'(flush), 32'd0);
        start = 1; start_pc = 32'h5;
        step();
        start = 0;
        chk("restart_pc", fetch_pc, 32'h5);
        chk("restart_done", 32'(done), 32'd0);

        exec_valid = 1; exec_is_halt = 1;
        step();
        idle_exec();
        start = 1; start_pc = 32'hFFFF_FFFF;
        step();
        start = 0;
        chk("wrap_pre", fetch_pc, 32'hFFFF_FFFF);
        step();
        chk("wrap_pc", fetch_pc, 32'h0);

        exec_valid = 1; exec_is_jump = 1; alu_result = 32'h123;
        step();
        idle_exec();
        reset_n = 0;
        step();
        reset_n = 1;
        chk("rstred_pc", fetch_pc, 32'h0);
        chk("rstred_flush", 32'(flush), 32'd0);
        chk("rstred_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset_n        = ($urandom_range(0, 199) != 0);
            start          = ($urandom_range(0, 3) == 0);
            start_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE
                                                         : $urandom;
            fetch_ready    = ($urandom_range(0, 3) != 0);
            exec_valid     = $urandom_range(0, 1) == 1;
            exec_is_branch = ($urandom_range(0, 3) == 0);
            exec_is_jump   = ($urandom_range(0, 7) == 0);
            exec_is_halt   = ($urandom_range(0, 19) == 0);
            exec_target    = $urandom;
            alu_result     = $urandom_range(0, 1) == 1 ? $urandom : 32'd0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
